// File: rtl/ps2_keyboard_pkg.sv
// Shared constants and types for the PS/2 keyboard MMIO receiver.
// Holds the register offsets, the register bit positions and the receiver state type.
package ps2_keyboard_pkg;

    localparam logic [1:0] REG_DATA    = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_CONTROL = 2'd2;

    localparam int DATA_VALID_BIT = 8;

    localparam int ST_NOT_EMPTY  = 0;
    localparam int ST_FULL       = 1;
    localparam int ST_OVERFLOW   = 2;
    localparam int ST_PARITY_ERR = 3;
    localparam int ST_FRAME_ERR  = 4;
    localparam int ST_COUNT_LSB  = 8;
    localparam int ST_COUNT_W    = 5;

    localparam int CTRL_IRQ_EN = 0;
    localparam int CTRL_CLEAR  = 1;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

endpackage

// File: rtl/ps2_keyboard_mmio_rx.sv
// PS/2 device-to-host frame receiver: input synchronisers, falling-edge detect,
// frame FSM and inactivity timeout. Result outputs are single-cycle pulses.
//
//   state  | meaning
//   IDLE   | waiting for a start bit (DAT=0 on a falling edge)
//   DATA   | shifting in 8 data bits, LSB first
//   PARITY | next falling edge carries the parity bit
//   STOP   | next falling edge carries the stop bit; frame is judged here
module ps2_rx
    import ps2_keyboard_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic       rx_valid,
    output logic [7:0] rx_byte,
    output logic       parity_err_pulse,
    output logic       frame_err_pulse
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TIMER_LOAD = TW'(TIMEOUT_CYCLES - 1);

    logic clk_s1, clk_s2, clk_prev;
    logic dat_s1, dat_s2;
    logic fall;

    rx_state_t     state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          parity_q, parity_d;
    logic [TW-1:0] timer_q;
    logic          timed_out;

    // Lines idle high, so the synchronisers reset high to avoid a false edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            clk_prev <= 1'b1;
            dat_s1   <= 1'b1;
            dat_s2   <= 1'b1;
        end else begin
            clk_s1   <= ps2_clk;
            clk_s2   <= clk_s1;
            clk_prev <= clk_s2;
            dat_s1   <= ps2_dat;
            dat_s2   <= dat_s1;
        end
    end

    assign fall = clk_prev & ~clk_s2;

    // Down-counter reloaded on every falling edge; terminal count aborts a partial frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            timer_q <= TIMER_LOAD;
        end else if (fall) begin
            timer_q <= TIMER_LOAD;
        end else if (timer_q != '0) begin
            timer_q <= timer_q - TW'(1);
        end
    end

    assign timed_out = (state_q != IDLE) && !fall && (timer_q == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            parity_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        bit_cnt_d        = bit_cnt_q;
        shift_d          = shift_q;
        parity_d         = parity_q;
        rx_valid         = 1'b0;
        parity_err_pulse = 1'b0;
        frame_err_pulse  = 1'b0;
        if (timed_out) begin
            state_d         = IDLE;
            frame_err_pulse = 1'b1;
        end else if (fall) begin
            unique case (state_q)
                IDLE: begin
                    if (!dat_s2) begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                    end
                end
                DATA: begin
                    shift_d   = {dat_s2, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = PARITY;
                    end
                end
                PARITY: begin
                    parity_d = dat_s2;
                    state_d  = STOP;
                end
                STOP: begin
                    if (dat_s2) begin
                        if (^{shift_q, parity_q}) begin
                            rx_valid = 1'b1;
                        end else begin
                            parity_err_pulse = 1'b1;
                        end
                    end else begin
                        frame_err_pulse = 1'b1;
                    end
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign rx_byte = shift_q;

endmodule

// File: rtl/ps2_keyboard_mmio.sv
// Memory-mapped PS/2 keyboard port: scan-code FIFO, DATA/STATUS/CONTROL registers
// and a registered level interrupt while data is pending.
module ps2_keyboard_mmio
    import ps2_keyboard_pkg::*;
#(
    parameter int FIFO_DEPTH     = 16,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic        Clock,
    input  logic        Reset_H,
    input  logic        Keyboard_Select_H,
    input  logic        AS_L,
    input  logic        WE_L,
    input  logic [31:0] Address,
    input  logic [3:0]  ByteEnable,
    input  logic [31:0] DataIn,
    output logic [31:0] DataOut,
    input  logic        PS2_CLK,
    input  logic        PS2_DAT,
    output logic        IRQ_Keyboard_H
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic       rx_valid;
    logic [7:0] rx_byte;
    logic       parity_err_pulse;
    logic       frame_err_pulse;

    ps2_rx #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rx (
        .clk              (Clock),
        .rst              (Reset_H),
        .ps2_clk          (PS2_CLK),
        .ps2_dat          (PS2_DAT),
        .rx_valid         (rx_valid),
        .rx_byte          (rx_byte),
        .parity_err_pulse (parity_err_pulse),
        .frame_err_pulse  (frame_err_pulse)
    );

    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr_q, wr_ptr_q;
    logic [CW-1:0] count_q;

    logic        access, access_q, pend_pop_q;
    logic        irq_en_q, overflow_q, parity_err_q, frame_err_q, irq_q;
    logic [1:0]  reg_sel;
    logic        not_empty, full;
    logic        pop, push_ok, overflow_set;
    logic        wr_strobe, clear, data_read;
    logic [31:0] read_data;
    logic        unused_bus;

    assign access    = Keyboard_Select_H & ~AS_L;
    assign reg_sel   = Address[3:2];
    assign not_empty = (count_q != '0);
    assign full      = (count_q == CW'(FIFO_DEPTH));

    // Pop is deferred to the end of the access so a held strobe consumes one entry.
    assign data_read    = access & WE_L & (reg_sel == REG_DATA) & not_empty;
    assign pop          = access_q & ~access & pend_pop_q & not_empty;
    assign push_ok      = rx_valid & (~full | pop);
    assign overflow_set = rx_valid & full & ~pop;
    assign wr_strobe    = access & ~access_q & ~WE_L & ByteEnable[0] & (reg_sel == REG_CONTROL);
    assign clear        = wr_strobe & DataIn[CTRL_CLEAR];

    always_ff @(posedge Clock) begin
        if (push_ok) begin
            fifo_mem[wr_ptr_q] <= rx_byte;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset_H) begin
            access_q     <= 1'b0;
            pend_pop_q   <= 1'b0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            irq_en_q     <= 1'b0;
            overflow_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            irq_q        <= 1'b0;
        end else begin
            access_q   <= access;
            pend_pop_q <= access & (pend_pop_q | data_read);
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            unique case ({push_ok, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            if (wr_strobe) begin
                irq_en_q <= DataIn[CTRL_IRQ_EN];
            end
            // A new error arriving in the same cycle as a clear is kept.
            overflow_q   <= (overflow_q & ~clear) | overflow_set;
            parity_err_q <= (parity_err_q & ~clear) | parity_err_pulse;
            frame_err_q  <= (frame_err_q & ~clear) | frame_err_pulse;
            irq_q        <= irq_en_q & not_empty;
        end
    end

    always_comb begin
        read_data = '0;
        unique case (reg_sel)
            REG_DATA: begin
                if (not_empty) begin
                    read_data[7:0]           = fifo_mem[rd_ptr_q];
                    read_data[DATA_VALID_BIT] = 1'b1;
                end
            end
            REG_STATUS: begin
                read_data[ST_NOT_EMPTY]                     = not_empty;
                read_data[ST_FULL]                          = full;
                read_data[ST_OVERFLOW]                      = overflow_q;
                read_data[ST_PARITY_ERR]                    = parity_err_q;
                read_data[ST_FRAME_ERR]                     = frame_err_q;
                read_data[ST_COUNT_LSB +: ST_COUNT_W]       = ST_COUNT_W'(count_q);
            end
            REG_CONTROL: begin
                read_data[CTRL_IRQ_EN] = irq_en_q;
            end
            default: read_data = '0;
        endcase
    end

    assign DataOut        = access ? read_data : '0;
    assign IRQ_Keyboard_H = irq_q;

    assign unused_bus = ^{Address[31:4], Address[1:0], ByteEnable[3:1], DataIn[31:2]};

endmodule

// File: tb/tb_ps2_keyboard_mmio.sv
// Self-checking bench: a queue-based model of the keyboard port is compared
// against DataOut and IRQ_Keyboard_H every cycle, plus fixed-value checks.
module tb_ps2_keyboard_mmio;

    localparam int DEPTH = 16;
    localparam int TMO   = 400;
    localparam int HALF  = 10;

    logic        Clock = 1'b0;
    logic        Reset_H;
    logic        sel, as_l, we_l;
    logic [31:0] addr, din, dout;
    logic [3:0]  be;
    logic        ps2_clk, ps2_dat, irq;

    always #5 Clock = ~Clock;

    ps2_keyboard_mmio #(
        .FIFO_DEPTH    (DEPTH),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .Clock            (Clock),
        .Reset_H          (Reset_H),
        .Keyboard_Select_H(sel),
        .AS_L             (as_l),
        .WE_L             (we_l),
        .Address          (addr),
        .ByteEnable       (be),
        .DataIn           (din),
        .DataOut          (dout),
        .PS2_CLK          (ps2_clk),
        .PS2_DAT          (ps2_dat),
        .IRQ_Keyboard_H   (irq)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h required 0x%08h at %0t", name, got, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0] m_q[$];
    bit   m_ovf, m_par, m_frm, m_irq_en, m_irq, m_acc_prev, m_pend;
    int   cyc       = 0;
    int   ev_cycle  = -1;
    int   ev_kind   = 0;   // 1 byte received, 2 parity error, 3 frame error
    logic [7:0] ev_byte;
    int   last_fall = 0;
    bit   checking  = 0;

    always @(posedge Clock) begin : model
        bit acc, pop, wr, new_irq;
        cyc++;
        acc = sel && !as_l;
        if (Reset_H) begin
            m_q.delete();
            m_ovf = 0; m_par = 0; m_frm = 0; m_irq_en = 0; m_irq = 0;
            m_acc_prev = 0; m_pend = 0; ev_kind = 0;
        end else begin
            new_irq = m_irq_en && (m_q.size() != 0);
            pop = m_acc_prev && !acc && m_pend && (m_q.size() != 0);
            wr  = acc && !m_acc_prev && !we_l && be[0] && (addr[3:2] == 2'd2);
            if (!acc) m_pend = 0;
            else if (we_l && addr[3:2] == 2'd0 && m_q.size() != 0) m_pend = 1;
            if (pop) void'(m_q.pop_front());
            if (wr) begin
                m_irq_en = din[0];
                if (din[1]) begin m_ovf = 0; m_par = 0; m_frm = 0; end
            end
            if (ev_kind != 0 && cyc == ev_cycle) begin
                case (ev_kind)
                    1: if (m_q.size() < DEPTH) m_q.push_back(ev_byte); else m_ovf = 1;
                    2: m_par = 1;
                    default: m_frm = 1;
                endcase
                ev_kind = 0;
            end
            m_acc_prev = acc;
            m_irq      = new_irq;
        end
    end

    function automatic logic [31:0] exp_reg(input logic [1:0] a);
        logic [31:0] v = 32'd0;
        int n = m_q.size();
        case (a)
            2'd0: if (n > 0) v = 32'h100 | 32'(m_q[0]);
            2'd1: v = 32'(n * 256 + m_frm * 16 + m_par * 8 + m_ovf * 4
                          + ((n == DEPTH) ? 2 : 0) + ((n != 0) ? 1 : 0));
            2'd2: v = 32'(m_irq_en);
            default: v = 32'd0;
        endcase
        return v;
    endfunction

    always @(negedge Clock) begin
        if (checking) begin
            logic [31:0] e;
            e = (sel && !as_l) ? exp_reg(addr[3:2]) : 32'd0;
            check("dataout", dout, e);
            check("irq", {31'd0, irq}, {31'd0, m_irq});
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge Clock);
        #1;
    endtask

    task automatic bus_idle();
        sel = 0; as_l = 1; we_l = 1; addr = 0; din = 0; be = 0;
    endtask

    task automatic cpu_read(input logic [1:0] a, input int hold, output logic [31:0] d);
        sel = 1; as_l = 0; we_l = 1; addr = {28'd0, a, 2'b00}; be = 4'hF;
        d = 32'd0;
        for (int k = 0; k < hold; k++) begin
            @(negedge Clock);
            if (k == 0) d = dout;
            tick(1);
        end
        bus_idle();
        tick(1);
    endtask

    task automatic cpu_write(input logic [1:0] a, input logic [31:0] d, input logic [3:0] b,
                             input int hold);
        sel = 1; as_l = 0; we_l = 0; addr = {28'd0, a, 2'b00}; din = d; be = b;
        tick(hold);
        bus_idle();
        tick(1);
    endtask

    task automatic sample_irq(input string name, input logic e);
        @(negedge Clock);
        check(name, {31'd0, irq}, {31'd0, e});
        tick(1);
    endtask

    task automatic send_bits(input logic [10:0] bits, input int nbits, input int kind,
                             input logic [7:0] b);
        for (int i = 0; i < nbits; i++) begin
            ps2_dat = bits[i];
            tick(HALF);
            ps2_clk = 0;
            last_fall = cyc;
            if (i == nbits - 1 && kind != 0) begin
                ev_byte  = b;
                ev_kind  = kind;
                ev_cycle = cyc + 3;
            end
            tick(HALF);
            ps2_clk = 1;
        end
        ps2_dat = 1;
        tick(HALF);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        logic par;
        int kind;
        par  = (~^b) ^ bad_par;
        kind = bad_stop ? 3 : (bad_par ? 2 : 1);
        send_bits({~bad_stop, par, b, 1'b0}, 11, kind, b);
    endtask

    task automatic send_glitch();
        send_bits(11'h7FF, 1, 0, 8'h00);
    endtask

    bit rnd_done;

    initial begin
        logic [31:0] d;
        bus_idle();
        ps2_clk = 1; ps2_dat = 1;
        Reset_H = 1;
        tick(1);
        checking = 1;
        tick(2);
        Reset_H = 0;
        tick(2);

        cpu_read(2'd1, 1, d);
        check("reset_status", d, 32'h0);
        sample_irq("reset_irq", 1'b0);

        cpu_write(2'd2, 32'h1, 4'hF, 1);
        send_frame(8'h1C, 0, 0);
        tick(2);
        cpu_read(2'd1, 1, d);
        check("one_byte_status", d, 32'h101);
        sample_irq("one_byte_irq", 1'b1);
        cpu_read(2'd0, 1, d);
        check("one_byte_data", d, 32'h11C);
        tick(2);
        cpu_read(2'd1, 1, d);
        check("drained_status", d, 32'h0);
        sample_irq("drained_irq", 1'b0);

        send_frame(8'h1C, 1, 0);
        cpu_read(2'd1, 1, d);
        check("parity_err_status", d, 32'h8);
        cpu_write(2'd2, 32'h2, 4'hF, 1);
        cpu_read(2'd1, 1, d);
        check("cleared_status", d, 32'h0);

        for (int i = 0; i < 17; i++) send_frame(8'(i), 0, 0);
        cpu_read(2'd1, 1, d);
        check("full_status", d, 32'h1007);
        for (int i = 0; i < 16; i++) begin
            cpu_read(2'd0, 1, d);
            check("full_drain_data", d, 32'h100 + 32'(i));
        end
        cpu_read(2'd1, 1, d);
        check("after_drain_status", d, 32'h4);
        cpu_write(2'd2, 32'h3, 4'hF, 1);

        send_bits(11'b000_0001_0100, 5, 0, 8'h00);
        ev_kind  = 3;
        ev_cycle = last_fall + 3 + TMO;
        tick(TMO + 20);
        cpu_read(2'd1, 1, d);
        check("timeout_status", d, 32'h10);
        send_frame(8'hF0, 0, 0);
        cpu_read(2'd0, 1, d);
        check("after_timeout_data", d, 32'h1F0);
        cpu_write(2'd2, 32'h3, 4'hF, 1);

        send_frame(8'hAA, 0, 0);
        send_frame(8'hBB, 0, 0);
        sel = 1; as_l = 0; we_l = 1; addr = 32'h0; be = 4'hF;
        for (int k = 0; k < 5; k++) begin
            @(negedge Clock);
            check("hold_data", dout, 32'h1AA);
            tick(1);
        end
        bus_idle();
        tick(2);
        cpu_read(2'd1, 1, d);
        check("hold_status", d, 32'h101);
        cpu_read(2'd0, 1, d);
        check("hold_next_data", d, 32'h1BB);

        send_frame(8'h55, 0, 0);
        sel = 1; as_l = 0; we_l = 1; addr = 32'h0; be = 4'hF;
        tick(2);
        Reset_H = 1;
        tick(1);
        Reset_H = 0;
        bus_idle();
        tick(2);
        cpu_read(2'd1, 1, d);
        check("mid_access_reset_status", d, 32'h0);
        cpu_write(2'd2, 32'h1, 4'hF, 1);

        rnd_done = 0;
        fork
            begin
                for (int f = 0; f < 30; f++) begin
                    int r;
                    r = $urandom_range(0, 9);
                    if (r == 0) send_glitch();
                    else send_frame(8'($urandom), r == 1, r == 2);
                end
                rnd_done = 1;
            end
            begin
                while (!rnd_done) begin
                    int r;
                    logic [31:0] rd;
                    tick($urandom_range(1, 5));
                    r = $urandom_range(0, 9);
                    if (r <= 5) cpu_read(2'd0, $urandom_range(1, 3), rd);
                    else if (r <= 7) cpu_read(2'($urandom_range(1, 3)), $urandom_range(1, 2), rd);
                    else if (r == 8) cpu_write(2'd2, {30'd0, 2'($urandom)},
                                               4'($urandom), $urandom_range(1, 3));
                    else cpu_write(2'($urandom_range(0, 3)), $urandom, 4'hF, 1);
                end
            end
        join

        for (int i = 0; i < DEPTH + 1; i++) cpu_read(2'd0, 1, d);
        tick(5);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: run did not complete, %0d/%0d", n_pass, n_total);
        $fatal(1);
    end

endmodule
